cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of execution-lane requesters (equals CPU_NUM_LANES).
REQ-002 SHALL have parameter NUM_CDB, default 2, the number of CDB broadcast ports (1 <= NUM_CDB <= NUM_REQ).
REQ-003 SHALL have parameter ROB_SIZE_CLOG, default 6, the robid width.
REQ-004 SHALL have parameter DATA_LEN, default 32, the result width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port global_rst_n, input, 1, the reset: synchronous, active-low.
REQ-007 SHALL have port flush, input, 1, a pipeline flush that discards all pending results.
REQ-008 SHALL have port req_v, input, NUM_REQ, the per-lane result valid.
REQ-009 SHALL have port req_robid, input, NUM_REQ x ROB_SIZE_CLOG, the per-lane result robid.
REQ-010 SHALL have port req_data, input, NUM_REQ x DATA_LEN, the per-lane result data.
REQ-011 SHALL have port req_rdy, output, NUM_REQ, meaning the lane may present a result this cycle.
REQ-012 SHALL have port cdb_v, output, NUM_CDB, the registered CDB port valid.
REQ-013 SHALL have port cdb_robid, output, NUM_CDB x ROB_SIZE_CLOG, the registered CDB robid.
REQ-014 SHALL have port cdb_data, output, NUM_CDB x DATA_LEN, the registered CDB data.
REQ-015 SHALL have port stall_cnt, output, 32, the count of lane-cycles spent holding an ungranted result.

Function
REQ-016 SHALL keep a one-entry holding buffer per lane (buf_v, buf_robid, buf_data).
REQ-017 SHALL drive req_rdy[i] = !buf_v[i], decoded from state only, with no combinational path from req_v.
REQ-018 SHALL ignore req_v[i] while req_rdy[i]=0; a lane asserting valid with rdy low is a protocol violation and is not captured.
REQ-019 SHALL define a lane candidate as its buffer entry if buf_v[i]=1, otherwise as its incoming req when req_v[i]=1.
REQ-020 SHALL each cycle grant up to NUM_CDB candidates, scanning lanes in round-robin order starting at rr_ptr; the k-th grant in scan order drives CDB port k.
REQ-021 SHALL register granted candidates onto cdb_v/robid/data on the next edge (latency 1 cycle from req_v to cdb_v when uncontended), and clear cdb_v on ports with no grant.
REQ-022 SHALL capture an ungranted incoming candidate into its lane buffer; SHALL keep an ungranted buffered entry; SHALL clear buf_v when the buffered entry is granted.
REQ-023 SHALL advance rr_ptr to (index of last granted lane + 1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0, and hold rr_ptr when there is no grant.
REQ-024 SHALL, on flush=1, clear all buf_v and cdb_v on the next edge, drop the same-cycle req_v, and hold rr_ptr; flush overrides grants.
REQ-025 SHALL never emit the same robid on two ports in one cycle, and SHALL never lose or duplicate an accepted result absent flush.
REQ-026 SHALL ensure that a lane holding a buffered result is granted within ceil(NUM_REQ/NUM_CDB) cycles.

Reset
REQ-027 SHALL, while global_rst_n=0 at an edge, clear buf_v, cdb_v, cdb_robid, cdb_data, rr_ptr and stall_cnt to 0; req_rdy then reads all-ones.
REQ-028 SHALL give reset priority over flush and requests; results in flight when reset asserts mid-operation are discarded.

Configuration
REQ-029 SHALL use macro CDB_ARB_PERF_CNT_EN: when defined, stall_cnt increments each cycle by the number of lanes with buf_v=1 and no grant, saturating at 0xFFFFFFFF; when undefined, stall_cnt is tied to 0 and no counter logic is built.

Verification (NUM_REQ=4, NUM_CDB=2)
REQ-030 SHALL cover: after reset, single req_v=0001 with robid 5, data 0xA5 -> next cycle cdb_v=01, cdb_robid[0]=5, cdb_data[0]=0xA5; req_rdy stays 1111.
REQ-031 SHALL cover: req_v=1111 with rr_ptr=0 -> lanes 0,1 go out on ports 0,1; lanes 2,3 are buffered, req_rdy=0011; next cycle lanes 2,3 go out, rr_ptr returns to 0.
REQ-032 SHALL cover: req_v=1111 held for 8 cycles with new data each time rdy allows -> every lane is granted at least once per 2 cycles, with no result lost or duplicated (scoreboard).
REQ-033 SHALL cover: flush asserted with buf_v=1100 and req_v=0011 -> next cycle cdb_v=00, req_rdy=1111, and no flushed robid appears afterward.
REQ-034 SHALL cover: global_rst_n=0 for one cycle mid-traffic -> all outputs 0, rr_ptr=0, req_rdy=1111 on the following cycle.
REQ-035 SHALL cover: with CDB_ARB_PERF_CNT_EN, req_v=1111 for one cycle -> stall_cnt=2 after the arbitration edge; without the macro, stall_cnt stays 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-lane one-entry holding buffers, round-robin grant of up to NUM_CDB results per cycle.
// Optional stall counter built only when CDB_ARB_PERF_CNT_EN is defined.

module cdb_arb_lane #(
  parameter int RW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          global_rst_n,
  input  logic          flush,
  input  logic          in_v,
  input  logic [RW-1:0] in_robid,
  input  logic [DW-1:0] in_data,
  input  logic          gnt,
  output logic          held,
  output logic          cand_v,
  output logic [RW-1:0] cand_robid,
  output logic [DW-1:0] cand_data
);
  logic [RW-1:0] h_robid;
  logic [DW-1:0] h_data;

  // A held entry masks the incoming request; the lane is not ready then.
  assign cand_v     = held | in_v;
  assign cand_robid = held ? h_robid : in_robid;
  assign cand_data  = held ? h_data  : in_data;

  always_ff @(posedge clk) begin
    if (!global_rst_n) begin
      held    <= 1'b0;
      h_robid <= '0;
      h_data  <= '0;
    end else if (flush) begin
      held <= 1'b0;
    end else if (held) begin
      if (gnt) held <= 1'b0;
    end else if (in_v && !gnt) begin
      held    <= 1'b1;
      h_robid <= in_robid;
      h_data  <= in_data;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_CDB       = 2,
  parameter int ROB_SIZE_CLOG = 6,
  parameter int DATA_LEN      = 32
) (
  input  logic                                    clk,
  input  logic                                    global_rst_n,
  input  logic                                    flush,
  input  logic [NUM_REQ-1:0]                      req_v,
  input  logic [NUM_REQ-1:0][ROB_SIZE_CLOG-1:0]   req_robid,
  input  logic [NUM_REQ-1:0][DATA_LEN-1:0]        req_data,
  output logic [NUM_REQ-1:0]                      req_rdy,
  output logic [NUM_CDB-1:0]                      cdb_v,
  output logic [NUM_CDB-1:0][ROB_SIZE_CLOG-1:0]   cdb_robid,
  output logic [NUM_CDB-1:0][DATA_LEN-1:0]        cdb_data,
  output logic [31:0]                             stall_cnt
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                    buf_v, cand_v, gnt;
  logic [NUM_REQ-1:0][ROB_SIZE_CLOG-1:0] cand_robid;
  logic [NUM_REQ-1:0][DATA_LEN-1:0]      cand_data;
  logic [NUM_CDB-1:0]                    nxt_v;
  logic [NUM_CDB-1:0][ROB_SIZE_CLOG-1:0] nxt_robid;
  logic [NUM_CDB-1:0][DATA_LEN-1:0]      nxt_data;
  logic [PW-1:0]                         rr_ptr, nxt_ptr;
  int                                    cnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    cdb_arb_lane #(.RW(ROB_SIZE_CLOG), .DW(DATA_LEN)) u_lane (
      .clk(clk), .global_rst_n(global_rst_n), .flush(flush),
      .in_v(req_v[i] & ~buf_v[i]), .in_robid(req_robid[i]), .in_data(req_data[i]),
      .gnt(gnt[i]), .held(buf_v[i]),
      .cand_v(cand_v[i]), .cand_robid(cand_robid[i]), .cand_data(cand_data[i])
    );
  end

  assign req_rdy = ~buf_v;

  // Scan lanes from rr_ptr; the k-th grant in scan order lands on port k.
  always_comb begin
    gnt       = '0;
    nxt_v     = '0;
    nxt_robid = '0;
    nxt_data  = '0;
    nxt_ptr   = rr_ptr;
    cnt       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == ((int'(rr_ptr) + k) % NUM_REQ) && cand_v[j] && cnt < NUM_CDB) begin
          gnt[j] = 1'b1;
          for (int p = 0; p < NUM_CDB; p++) begin
            if (p == cnt) begin
              nxt_v[p]     = 1'b1;
              nxt_robid[p] = cand_robid[j];
              nxt_data[p]  = cand_data[j];
            end
          end
          nxt_ptr = PW'((j + 1) % NUM_REQ);
          cnt     = cnt + 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!global_rst_n) begin
      cdb_v     <= '0;
      cdb_robid <= '0;
      cdb_data  <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_v <= '0;
    end else begin
      cdb_v     <= nxt_v;
      cdb_robid <= nxt_robid;
      cdb_data  <= nxt_data;
      rr_ptr    <= nxt_ptr;
    end
  end

`ifdef CDB_ARB_PERF_CNT_EN
  logic [31:0] stall_q, stall_inc;
  logic [32:0] stall_sum;

  // Counts the lanes left holding a result after this edge (ungranted candidates).
  always_comb begin
    stall_inc = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (cand_v[i] && !gnt[i]) stall_inc = stall_inc + 32'd1;
    stall_sum = {1'b0, stall_q} + {1'b0, stall_inc};
  end

  always_ff @(posedge clk) begin
    if (!global_rst_n)  stall_q <= '0;
    else if (!flush)    stall_q <= stall_sum[32] ? '1 : stall_sum[31:0];
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (4 lanes, 2 ports): stimulus pushes expected CDB beats, a negedge monitor pops and compares.
module tb_cdb_arbiter;
  localparam int NR = 4, NC = 2, RW = 6, DW = 32;

  logic                     clk = 1'b0;
  logic                     global_rst_n = 1'b0;
  logic                     flush = 1'b0;
  logic [NR-1:0]            req_v = '0;
  logic [NR-1:0][RW-1:0]    req_robid = '0;
  logic [NR-1:0][DW-1:0]    req_data = '0;
  logic [NR-1:0]            req_rdy;
  logic [NC-1:0]            cdb_v;
  logic [NC-1:0][RW-1:0]    cdb_robid;
  logic [NC-1:0][DW-1:0]    cdb_data;
  logic [31:0]              stall_cnt;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC), .ROB_SIZE_CLOG(RW), .DATA_LEN(DW)) dut (
    .clk(clk), .global_rst_n(global_rst_n), .flush(flush),
    .req_v(req_v), .req_robid(req_robid), .req_data(req_data), .req_rdy(req_rdy),
    .cdb_v(cdb_v), .cdb_robid(cdb_robid), .cdb_data(cdb_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [5:0]  robid;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic mon_en = 1'b0;

  function automatic logic [31:0] dat(input int r);
    return 32'hC0DE_0000 + 32'(r);
  endfunction

  task automatic push(input int p, input int r);
    exp_t e;
    e.port = p; e.robid = 6'(r); e.data = dat(r);
    exp_q.push_back(e);
  endtask

  task automatic lane(input int l, input int r);
    req_robid[l] = 6'(r);
    req_data[l]  = dat(r);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor: every valid port must match the next expected beat in order.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int p = 0; p < NC; p++) begin
        if (cdb_v[p]) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: port %0d robid %0d data %0h, none expected", p, cdb_robid[p], cdb_data[p]);
          end else begin
            e = exp_q.pop_front();
            if (e.port != p || e.robid !== cdb_robid[p] || e.data !== cdb_data[p]) begin
              fails++;
              $display("FAIL beat: got port %0d robid %0d data %0h expected port %0d robid %0d data %0h",
                       p, cdb_robid[p], cdb_data[p], e.port, e.robid, e.data);
            end
          end
        end
      end
      if (cdb_v == 2'b11) begin
        tests++;
        if (cdb_robid[0] == cdb_robid[1]) begin
          fails++;
          $display("FAIL dup_robid: both ports robid %0d required distinct", cdb_robid[0]);
        end
      end
    end
  end

  initial begin
    // Reset
    step(); step();
    global_rst_n = 1'b1;
    mon_en = 1'b1;
    chk("rst_cdb_v", 64'(cdb_v), 64'h0);
    chk("rst_rdy", 64'(req_rdy), 64'hF);
    chk("rst_stall", stall_cnt, 64'h0);

    // Single uncontended request, robid 5 data A5
    req_v = 4'b0001; req_robid[0] = 6'd5; req_data[0] = 32'hA5;
    begin exp_t e; e.port = 0; e.robid = 6'd5; e.data = 32'hA5; exp_q.push_back(e); end
    chk("single_rdy_pre", 64'(req_rdy), 64'hF);
    step();
    req_v = '0;
    chk("single_rdy_post", 64'(req_rdy), 64'hF);
    chk("single_cdb_v", 64'(cdb_v), 64'h1);

    // Lane 3 alone brings rr_ptr back to 0
    req_v = 4'b1000; lane(3, 7); push(0, 7);
    step();
    req_v = '0;

    // All four lanes contend from rr_ptr=0
    req_v = 4'b1111;
    for (int l = 0; l < NR; l++) lane(l, 10 + l);
    push(0, 10); push(1, 11); push(0, 12); push(1, 13);
    step();
    req_v = '0;
    chk("burst_rdy", 64'(req_rdy), 64'h3);
`ifdef CDB_ARB_PERF_CNT_EN
    chk("stall_cnt_two", stall_cnt, 64'd2);
`else
    chk("stall_cnt_off", stall_cnt, 64'd0);
`endif
    step();
    chk("burst_rdy_drained", 64'(req_rdy), 64'hF);

    // Sustained 1111 for 8 cycles; grants alternate lane pairs {0,1},{2,3}
    push(0, 16); push(1, 17);
    for (int c = 1; c <= 8; c++) begin
      if (c % 2 == 1) begin push(0, 16 + (c-1)*4 + 2); push(1, 16 + (c-1)*4 + 3); end
      else            begin push(0, 16 + (c-1)*4 + 0); push(1, 16 + (c-1)*4 + 1); end
    end
    req_v = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        for (int l = 0; l < NR; l++) lane(l, 16 + l);
        chk("sustain_rdy", 64'(req_rdy), 64'hF);
      end else if (c % 2 == 1) begin
        lane(0, 16 + c*4); lane(1, 16 + c*4 + 1);
        chk("sustain_rdy", 64'(req_rdy), 64'h3);
      end else begin
        lane(2, 16 + c*4 + 2); lane(3, 16 + c*4 + 3);
        chk("sustain_rdy", 64'(req_rdy), 64'hC);
      end
      step();
    end
    req_v = '0;
    step();
    chk("sustain_rdy_end", 64'(req_rdy), 64'hF);

    // Flush with lanes 2,3 buffered and lanes 0,1 requesting
    req_v = 4'b1000; lane(3, 49); push(0, 49);
    step();
    req_v = 4'b1111;
    for (int l = 0; l < NR; l++) lane(l, 50 + l);
    push(0, 50); push(1, 51);
    step();
    chk("preflush_rdy", 64'(req_rdy), 64'h3);
    req_v = 4'b0011; lane(0, 54); lane(1, 55); flush = 1'b1;
    step();
    flush = 1'b0; req_v = '0;
    chk("flush_cdb_v", 64'(cdb_v), 64'h0);
    chk("flush_rdy", 64'(req_rdy), 64'hF);
    step(); step(); step();
    chk("postflush_cdb_v", 64'(cdb_v), 64'h0);

    // Reset mid-traffic (rr_ptr held at 2 across flush)
    req_v = 4'b1111;
    for (int l = 0; l < NR; l++) lane(l, 56 + l);
    push(0, 58); push(1, 59);
    step();
    global_rst_n = 1'b0;
    for (int l = 0; l < NR; l++) lane(l, 60 + l);
    step();
    global_rst_n = 1'b1; req_v = '0;
    chk("midrst_cdb_v", 64'(cdb_v), 64'h0);
    chk("midrst_robid", 64'(cdb_robid), 64'h0);
    chk("midrst_data", 64'(cdb_data), 64'h0);
    chk("midrst_rdy", 64'(req_rdy), 64'hF);
    chk("midrst_stall", stall_cnt, 64'h0);

    // rr_ptr back at 0: lanes 0,1 first
    req_v = 4'b1111;
    for (int l = 0; l < NR; l++) lane(l, 1 + l);
    push(0, 1); push(1, 2); push(0, 3); push(1, 4);
    step();
    req_v = '0;
    step(); step();
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
